// File: rtl/secuencia_gen.sv
// Serial pattern generator: shifts a captured WIDTH-bit pattern out MSB-first,
// pads each frame with GAP zero bits, and either repeats or pulses done.
module secuencia_gen #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned GAP   = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] pattern,
    input  logic             repeat_en,
    input  logic             stop,
    output logic             w,
    output logic             busy,
    output logic             done
);

    localparam int unsigned BCW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned GCW = (GAP > 0) ? $clog2(GAP + 1) : 1;
    localparam logic [BCW-1:0] BIT_LAST = BCW'(WIDTH - 1);
    localparam logic [GCW-1:0] GAP_LAST = GCW'((GAP > 0) ? GAP - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] shreg, shreg_n;
    logic [WIDTH-1:0] saved, saved_n;
    logic [BCW-1:0]   bitcnt, bitcnt_n;
    logic [GCW-1:0]   gapcnt, gapcnt_n;
    logic             stop_l, stop_l_n;
    logic             w_n, busy_n, done_n;
    logic             rep_ok;

    // Repeat only when requested and no stop has been seen, including this cycle.
    assign rep_ok = repeat_en && !stop_l && !stop;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= S_IDLE;
            shreg  <= '0;
            saved  <= '0;
            bitcnt <= '0;
            gapcnt <= '0;
            stop_l <= 1'b0;
            w      <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_n;
            shreg  <= shreg_n;
            saved  <= saved_n;
            bitcnt <= bitcnt_n;
            gapcnt <= gapcnt_n;
            stop_l <= stop_l_n;
            w      <= w_n;
            busy   <= busy_n;
            done   <= done_n;
        end
    end

    always_comb begin
        state_n  = state;
        shreg_n  = shreg;
        saved_n  = saved;
        bitcnt_n = bitcnt;
        gapcnt_n = gapcnt;
        stop_l_n = stop_l;
        done_n   = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    shreg_n  = pattern;
                    saved_n  = pattern;
                    bitcnt_n = '0;
                    stop_l_n = 1'b0;
                    state_n  = S_SEND;
                end
            end

            S_SEND: begin
                shreg_n  = {shreg[WIDTH-2:0], 1'b0};
                bitcnt_n = bitcnt + BCW'(1);
                if (stop) begin
                    stop_l_n = 1'b1;
                end
                if (bitcnt == BIT_LAST) begin
                    if (GAP > 0) begin
                        gapcnt_n = '0;
                        state_n  = S_GAP;
                    end else if (rep_ok) begin
                        shreg_n  = saved;
                        bitcnt_n = '0;
                        state_n  = S_SEND;
                    end else begin
                        state_n = S_IDLE;
                        done_n  = 1'b1;
                    end
                end
            end

            S_GAP: begin
                gapcnt_n = gapcnt + GCW'(1);
                if (stop) begin
                    stop_l_n = 1'b1;
                end
                // End-of-frame decision on the last gap bit.
                if (gapcnt == GAP_LAST) begin
                    if (rep_ok) begin
                        shreg_n  = saved;
                        bitcnt_n = '0;
                        state_n  = S_SEND;
                    end else begin
                        state_n = S_IDLE;
                        done_n  = 1'b1;
                    end
                end
            end

            default: begin
                state_n = S_IDLE;
            end
        endcase

        // Output registers load the values the next state will present.
        w_n    = (state_n == S_SEND) ? shreg_n[WIDTH-1] : 1'b0;
        busy_n = (state_n != S_IDLE);
    end

endmodule

// File: doc/secuencia_gen.md
# secuencia_gen

Serial pattern generator: the transmit side of the serial bit input `w` that the Moore/Mealy sequence detectors consume. On a start request it captures a WIDTH-bit pattern and shifts it out MSB-first, one bit per clock. Each frame is followed by a programmable run of zero bits, which returns a downstream detector to its idle state. Frames either repeat continuously or end with a one-cycle completion pulse. It drives detector benches on the board and in simulation.

## Interface
- `WIDTH`, 8: pattern length in bits (≥2).
- `GAP`, 2: number of forced-zero bits after each frame (≥0).
- `clk`  in  1  system clock, all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low reset; the block is held in reset while `reset`=0.
- `start`  in  1  frame request; sampled only in IDLE.
- `pattern`  in  WIDTH  bits to send; captured on accepted `start`.
- `repeat_en`  in  1  sampled at end of each gap; 1 = resend captured pattern.
- `stop`  in  1  pulse; latched; suppresses the next repeat.
- `w`  out  1  serial bit stream to the detector.
- `busy`  out  1  high from first frame bit through last gap bit.
- `done`  out  1  one-cycle pulse on return to IDLE.

## Operation
- Three-state FSM: IDLE, SEND, GAP. Registers: state, `shreg`[WIDTH-1:0], `saved`[WIDTH-1:0], bit counter (clog2(WIDTH) bits), gap counter (clog2(GAP+1) bits, min 1), `stop_l`, `done`.
- Reset (async, `reset`=0): state=IDLE, `shreg`=0, `saved`=0, counters=0, `stop_l`=0. Outputs: `w`=0, `busy`=0, `done`=0.
- IDLE: `w`=0, `busy`=0. On `start`=1: `shreg`←`pattern`, `saved`←`pattern`, bit counter←0, `stop_l`←0, go to SEND.
- SEND: `w`=`shreg`[WIDTH-1]. Each cycle `shreg` shifts left with zero fill and the bit counter increments. After the bit with counter=WIDTH-1:
  - GAP>0: go to GAP with gap counter←0.
  - GAP=0: take the end-of-frame decision directly.
- GAP: `w`=0. The gap counter increments each cycle. After GAP cycles, take the end-of-frame decision.
- End-of-frame decision:
  - `repeat_en`=1 and `stop_l`=0 (and `stop`=0 in that cycle): `shreg`←`saved`, bit counter←0, go to SEND with no idle bit.
  - Otherwise: go to IDLE and assert `done` for one cycle.
- `stop`:
  - A 1 in any non-IDLE cycle sets `stop_l`.
  - Never aborts a frame or a gap in progress. The current frame and its gap always complete.
  - Cleared on an accepted `start`.
- `start` while not in IDLE is ignored. `pattern` changes during SEND/GAP have no effect.
- `w` and `busy` are decoded only from registered state/`shreg`. There is no combinational path from any input to any output.

## Timing
- `start` sampled high at edge k (IDLE): `w` carries `pattern`[WIDTH-1-i] during cycle k+1+i, for i=0..WIDTH-1.
- Gap zeros occupy cycles k+1+WIDTH … k+WIDTH+GAP.
- Single frame: `busy`=1 for cycles k+1 … k+WIDTH+GAP. `done`=1 in cycle k+WIDTH+GAP+1, with `busy`=0.
- A `start` high in the `done` cycle is accepted; the next frame begins the following cycle.
- Repeat: the first bit of frame n+1 immediately follows the last gap bit of frame n. The period is exactly WIDTH+GAP cycles and `busy` stays high throughout.
- `repeat_en` is sampled only in the last gap cycle (last SEND cycle when GAP=0).
- `reset` asserted mid-frame: `w`, `busy` and `done` go to 0 immediately, without waiting for a clock edge. After release the block is in IDLE and waits for `start`.

## Test plan
- Reset: hold `reset`=0 for 3 cycles with `start`=1 → `w`=0, `busy`=0, `done`=0 throughout. Release `reset` with `start`=0 → block stays IDLE.
- Single frame: WIDTH=8, GAP=2, `pattern`=8'b0110_1110, `repeat_en`=0, `start` pulse at edge k:
  - `w` = 0,1,1,0,1,1,1,0,0,0 over cycles k+1…k+10.
  - `busy` high for those 10 cycles; `done` high only in cycle k+11.
  - Attached detector: `z`=1 in the cycles after each second consecutive 1.
- Repeat with stop: `pattern`=8'hA5, `repeat_en`=1:
  - `w` period is 10 cycles with no extra idle bit.
  - `stop` pulsed in bit 3 of frame 2 → frame 2 and its gap complete, then `done` fires and there is no frame 3.
- Ignored start: a second `start` during SEND with `pattern`=8'hFF → transmitted bits still match the first captured pattern.
- Back-to-back start and GAP=0: `start` held high from the `done` cycle → the next frame's first bit appears the following cycle. With GAP=0, repeated 8'h81 gives `w` = 1,0,0,0,0,0,0,1,1,0,… with no zeros inserted between frames.
- Async reset mid-frame: `reset` driven low at bit 4 → `w`, `busy` and `done` drop to 0 before the next edge. After release, a new `start` sends the full new pattern from its MSB.
